operand_entry_ctrl: RTL
=======================

# operand_entry_ctrl

Sequential front-end for the 4-bit binary calculator that sequences operand entry from the board switches into the A/B operand registers. It turns push-button presses into single-cycle `load` strobes with the matching `write_addr` (0 = A, 1 = B). It is the source of the `write_addr`/`load` pair consumed by the 1-to-2 load-select decoder. It also tells the ALU/display when both operands are valid.

## Interface
- `WIDTH`, 4: operand width in bits.
- `SYNC_STAGES`, 2: button synchronizer depth, ≥2.

- `clk` in 1: system clock, all logic on rising edge.
- `reset` in 1: synchronous, active-high reset.
- `btn_enter` in 1: raw (debounced, asynchronous) enter button, active-high.
- `clear` in 1: synchronous, active-high; abandons entry and returns to operand-A entry.
- `sw_data` in WIDTH: operand value from switches.
- `write_addr` out 1: register select for `load`; 0 = A, 1 = B.
- `load` out 1: one-cycle load strobe to the decoder.
- `data_out` out WIDTH: operand value accompanying `load`, held until next load.
- `ready` out 1: high while both A and B hold operands from the current entry round.
- `phase` out 2: state code for LEDs; 00 = WAIT_A, 01 = WAIT_B, 10 = READY.

## Operation
- **Button path**
  - `btn_enter` passes through a SYNC_STAGES flop chain and then a `prev` flop.
  - `press` = last sync stage & ~`prev`, which is a rising edge only.
  - A button held high yields exactly one press.
- **States:** WAIT_A (reset state), WAIT_B, READY.
  - WAIT_A + press: `load`=1, `write_addr`=0, `data_out`=`sw_data`; go to WAIT_B.
  - WAIT_B + press: `load`=1, `write_addr`=1, `data_out`=`sw_data`; go to READY.
  - READY + press: starts a new round. Load A (`write_addr`=0) and go to WAIT_B; `ready` drops.
  - No press: hold state; `load`=0; `write_addr` and `data_out` hold their last values.
- `clear` (any state): go to WAIT_A, `load`=0, `ready`=0. `write_addr` and `data_out` hold.
- `clear` with a simultaneous press: `clear` wins and the press is discarded (no load).
- `ready` = 1 only in READY.
- `phase` is derived directly from the state register.
- All outputs are registered. `write_addr`, `data_out` and `load` update on the same edge, so they are always mutually consistent when `load`=1.
- `sw_data` is sampled only on the edge that sets `load`; changes at other times have no effect.
- **Reset values**
  - State WAIT_A; `load`=0, `write_addr`=0, `data_out`=0, `ready`=0, `phase`=00.
  - All sync flops and `prev` reset to 1. A button held through reset release, or released afterward, produces no press. A press requires a fresh 0→1 transition after reset.
- `reset` mid-round (e.g. in WAIT_B) discards the round. A is not considered loaded afterward.

## Timing
- **Press latency:** if `btn_enter` is first sampled high at edge k (after having been sampled low), `load` is high from edge k+SYNC_STAGES to edge k+SYNC_STAGES+1. That is exactly one cycle.
- State, `ready` and `phase` change on the same edge that raises `load`.
  - `ready` rises together with the B load strobe.
  - `ready` falls together with the next A load strobe, or on the edge after `clear`/`reset` is sampled.
- Minimum press spacing: the button must be low for at least one sampled cycle between presses. Presses on back-to-back edges cannot occur by construction.
- `clear`/`reset` take effect on the edge where they are sampled high. The next edge shows WAIT_A.
- A press in flight in the sync chain when `clear` is sampled is discarded only if its `press` cycle coincides with `clear`. Otherwise it is processed normally in WAIT_A.
- No combinational path from any input to any output.

## Test plan
- **Reset:** hold `reset` 3 cycles with `btn_enter`=1, then release and keep the button high 10 cycles. Required: `load` stays 0, `phase`=00, all outputs 0.
- **Basic entry**
  - `sw_data`=4'h5, pulse button 4 cycles: `load` for 1 cycle at k+2 with `write_addr`=0, `data_out`=5, `phase`→01.
  - Then `sw_data`=4'hA, press again: `load` with `write_addr`=1, `data_out`=A, `ready`=1, `phase`=10.
- **Held button:** hold `btn_enter` high 20 cycles in WAIT_A. Required: exactly one `load` pulse.
- **New round:** from READY, `sw_data`=4'h3, press. Required: `load` with `write_addr`=0, `data_out`=3, `ready`→0, `phase`=01.
- **Clear collision:** in WAIT_B, assert `clear` on the cycle `press` is high. Required: no `load`, `phase`=00, `ready`=0, `data_out` unchanged.
- **Reset mid-round:** in WAIT_B, assert `reset` 1 cycle. Required: `phase`=00, `data_out`=0. The next press loads A (`write_addr`=0).

Source files
------------

// File: rtl/operand_entry_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : operand_entry_ctrl
//  Description : Operand-entry sequencer for the 4-bit calculator. Turns
//                enter-button presses into single-cycle load strobes that
//                steer the switch value into operand register A or B, and
//                reports when both operands of the current round are valid.
//
//  Ports
//    clk         in   system clock, rising edge
//    reset       in   synchronous active-high reset
//    btn_enter   in   asynchronous (debounced) enter button, active-high
//    clear       in   synchronous active-high, abandons the entry round
//    sw_data     in   [WIDTH-1:0] operand value from the switches
//    write_addr  out  register select for load (0 = A, 1 = B)
//    load        out  one-cycle load strobe
//    data_out    out  [WIDTH-1:0] operand captured with load, held after
//    ready       out  high while A and B both hold operands of this round
//    phase       out  [1:0] state code: 00 WAIT_A, 01 WAIT_B, 10 READY
//
//  Revision    : 1.0  initial release
// ============================================================================
module operand_entry_ctrl #(
    parameter int WIDTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             btn_enter,
    input  logic             clear,
    input  logic [WIDTH-1:0] sw_data,
    output logic             write_addr,
    output logic             load,
    output logic [WIDTH-1:0] data_out,
    output logic             ready,
    output logic [1:0]       phase
);

    localparam int c_SYNC_LAST = SYNC_STAGES - 1;

    // The encodings double as the LED phase code.
    typedef enum logic [1:0] {
        ST_WAIT_A = 2'b00,
        ST_WAIT_B = 2'b01,
        ST_READY  = 2'b10
    } state_t;

    // ------------------------------------------------------------------
    // Registers and their next-state values
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] r_sync_q;
    logic [SYNC_STAGES-1:0] w_sync_d;
    logic                   r_prev_q;
    logic                   w_prev_d;
    state_t                 r_state_q;
    state_t                 w_state_d;
    logic                   r_load_q;
    logic                   w_load_d;
    logic                   r_write_addr_q;
    logic                   w_write_addr_d;
    logic [WIDTH-1:0]       r_data_out_q;
    logic [WIDTH-1:0]       w_data_out_d;
    logic                   r_ready_q;
    logic                   w_ready_d;

    logic                   w_press;

    // ------------------------------------------------------------------
    // Button synchronizer: stage 0 samples the raw pin, each later stage
    // takes the previous one.
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync_chain
        if (gi == 0) begin : g_first
            assign w_sync_d[gi] = btn_enter;
        end else begin : g_rest
            assign w_sync_d[gi] = r_sync_q[gi-1];
        end
    end

    assign w_prev_d = r_sync_q[c_SYNC_LAST];

    // Rising edge of the synchronized button. Because the chain and prev
    // reset to 1, a button held across reset release never looks like a
    // fresh press.
    assign w_press = r_sync_q[c_SYNC_LAST] & ~r_prev_q;

    // ------------------------------------------------------------------
    // Entry sequencing
    // ------------------------------------------------------------------
    always_comb begin
        w_state_d      = r_state_q;
        w_load_d       = 1'b0;
        w_write_addr_d = r_write_addr_q;
        w_data_out_d   = r_data_out_q;

        if (clear) begin
            // clear outranks a coincident press; the press is dropped.
            w_state_d = ST_WAIT_A;
        end else if (w_press) begin
            case (r_state_q)
                ST_WAIT_B: begin
                    w_load_d       = 1'b1;
                    w_write_addr_d = 1'b1;
                    w_data_out_d   = sw_data;
                    w_state_d      = ST_READY;
                end
                // From READY a press begins a fresh round with operand A.
                ST_WAIT_A, ST_READY: begin
                    w_load_d       = 1'b1;
                    w_write_addr_d = 1'b0;
                    w_data_out_d   = sw_data;
                    w_state_d      = ST_WAIT_B;
                end
                default: begin
                    w_state_d = ST_WAIT_A;
                end
            endcase
        end else if (r_state_q != ST_WAIT_A && r_state_q != ST_WAIT_B
                     && r_state_q != ST_READY) begin
            // Unused code 2'b11: fall back to the start of entry.
            w_state_d = ST_WAIT_A;
        end

        // Registered from the next state so ready moves on the same edge
        // as the load that completes or restarts a round.
        w_ready_d = (w_state_d == ST_READY);
    end

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync_q       <= '1;
            r_prev_q       <= 1'b1;
            r_state_q      <= ST_WAIT_A;
            r_load_q       <= 1'b0;
            r_write_addr_q <= 1'b0;
            r_data_out_q   <= '0;
            r_ready_q      <= 1'b0;
        end else begin
            r_sync_q       <= w_sync_d;
            r_prev_q       <= w_prev_d;
            r_state_q      <= w_state_d;
            r_load_q       <= w_load_d;
            r_write_addr_q <= w_write_addr_d;
            r_data_out_q   <= w_data_out_d;
            r_ready_q      <= w_ready_d;
        end
    end

    assign load       = r_load_q;
    assign write_addr = r_write_addr_q;
    assign data_out   = r_data_out_q;
    assign ready      = r_ready_q;
    assign phase      = r_state_q;

endmodule
`default_nettype wire
